// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM sequencing the shared ALU, PC, IR/MDR, regfile and a
// ready-stretched unified memory port; exports state and a retired-instruction counter.
module mips_mc_ctrl #(
   parameter int CNT_W        = 32,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             branch_ne,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             ext_zero,
   output logic [3:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] instr_retired
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEM_ADR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
      MEM_WR = 4'd5, EXEC = 4'd6, ALU_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
      IMM_EXEC = 4'd10, IMM_WB = 4'd11, JR = 4'd12, HALT = 4'd13
   } state_t;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, F_JR = 6'h08;
   state_t cur, nxt;
   logic pw, pwc, mr, mw, irw, rw;
   logic unused_zero;
   // zero is consumed by the datapath together with pc_write_cond/branch_ne
   assign unused_zero = zero;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cur           <= FETCH;
         instr_retired <= '0;
      end else begin
         cur <= nxt;
         if (nxt == FETCH && cur != FETCH) instr_retired <= instr_retired + 1'b1;
      end
   always_comb begin
      nxt        = cur;
      pw         = 1'b0;
      pwc        = 1'b0;
      mr         = 1'b0;
      mw         = 1'b0;
      irw        = 1'b0;
      rw         = 1'b0;
      branch_ne  = 1'b0;
      pc_src     = 2'd0;
      iord       = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 3'd0;
      ext_zero   = 1'b0;
      case (cur)
         FETCH: begin
            mr        = 1'b1;
            alu_src_b = 2'd1;
            irw       = mem_ready;
            pw        = mem_ready;
            nxt       = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'd3;
            if (op == OP_LW || op == OP_SW) nxt = MEM_ADR;
            else if (op == OP_R) nxt = (funct == F_JR) ? JR : EXEC;
            else if (op == OP_BEQ || op == OP_BNE) nxt = BRANCH;
            else if (op == OP_J || op == OP_JAL) nxt = JUMP;
            else if (op == OP_ADDI || op == OP_ADDIU || op == OP_ORI || op == OP_LUI || op == OP_SLTI)
               nxt = IMM_EXEC;
            else nxt = ILLEGAL_HALT ? HALT : FETCH;
         end
         MEM_ADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            nxt       = (op == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            iord = 1'b1;
            mr   = 1'b1;
            nxt  = mem_ready ? MEM_WB : MEM_RD;
         end
         MEM_WB: begin
            rw         = 1'b1;
            mem_to_reg = 2'd1;
            nxt        = FETCH;
         end
         MEM_WR: begin
            iord = 1'b1;
            mw   = 1'b1;
            nxt  = mem_ready ? FETCH : MEM_WR;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 3'd2;
            nxt       = ALU_WB;
         end
         ALU_WB: begin
            rw      = 1'b1;
            reg_dst = 2'd1;
            nxt     = FETCH;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 3'd1;
            pc_src    = 2'd1;
            pwc       = 1'b1;
            branch_ne = (op == OP_BNE);
            nxt       = FETCH;
         end
         JUMP: begin
            pc_src     = 2'd2;
            pw         = 1'b1;
            rw         = (op == OP_JAL);
            reg_dst    = (op == OP_JAL) ? 2'd2 : 2'd0;
            mem_to_reg = (op == OP_JAL) ? 2'd2 : 2'd0;
            nxt        = FETCH;
         end
         IMM_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = (op == OP_ORI) ? 3'd3 : (op == OP_LUI) ? 3'd4 : (op == OP_SLTI) ? 3'd5 : 3'd0;
            ext_zero  = (op == OP_ORI);
            nxt       = IMM_WB;
         end
         IMM_WB: begin
            rw  = 1'b1;
            nxt = FETCH;
         end
         JR: begin
            pc_src = 2'd3;
            pw     = 1'b1;
            nxt    = FETCH;
         end
         HALT: nxt = HALT;
         default: nxt = FETCH;
      endcase
   end
   // strobes are held low for the whole time reset is asserted
   assign pc_write      = pw & rst;
   assign pc_write_cond = pwc & rst;
   assign mem_read      = mr & rst;
   assign mem_write     = mw & rst;
   assign ir_write      = irw & rst;
   assign reg_write     = rw & rst;
   assign state         = cur;
   assign halted        = (cur == HALT);
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed scoreboard bench; expected state/control per cycle is queued with the
// stimulus and popped as the DUT steps. A second instance covers ILLEGAL_HALT=0.
module tb_mips_mc_ctrl;
   localparam int CW = 32;
   logic clk = 1'b0, rst = 1'b0, zero = 1'b0, mem_ready = 1'b0;
   logic [5:0] op = 6'h00, funct = 6'h00;
   logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, reg_write;
   logic alu_src_a, ext_zero, halted;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic [CW-1:0] instr_retired;
   logic b_pc_write, b_pc_write_cond, b_branch_ne, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_write;
   logic b_alu_src_a, b_ext_zero, b_halted;
   logic [1:0] b_pc_src, b_reg_dst, b_mem_to_reg, b_alu_src_b;
   logic [2:0] b_alu_op;
   logic [3:0] b_state;
   logic [CW-1:0] b_instr_retired;
   logic [13:0] ctl_obs;
   int ncmp = 0, nfail = 0, pcw_n = 0, irw_n = 0, rw_n = 0;
   typedef struct {
      logic [3:0]  st;
      logic        rdy;
      logic        ck;
      logic [13:0] ctl;
   } item_t;
   item_t q[$];

   mips_mc_ctrl #(.CNT_W(CW), .ILLEGAL_HALT(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .pc_src(pc_src),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_zero(ext_zero), .state(state), .halted(halted),
      .instr_retired(instr_retired));

   mips_mc_ctrl #(.CNT_W(CW), .ILLEGAL_HALT(1'b0)) dut_nop (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .branch_ne(b_branch_ne), .pc_src(b_pc_src),
      .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
      .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a),
      .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .ext_zero(b_ext_zero), .state(b_state),
      .halted(b_halted), .instr_retired(b_instr_retired));

   always #5 clk = ~clk;
   assign ctl_obs = {pc_write, pc_write_cond, branch_ne, pc_src, reg_write, reg_dst, mem_to_reg, alu_op, ext_zero};

   function automatic logic [13:0] cw(input logic pw, input logic pwc, input logic bn, input logic [1:0] ps,
                                      input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                      input logic [2:0] ao, input logic ez);
      return {pw, pwc, bn, ps, rw, rd, m2r, ao, ez};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      ncmp++;
      assert (obs === want) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic ps(input logic [3:0] st, input logic rdy);
      item_t it;
      it.st = st; it.rdy = rdy; it.ck = 1'b0; it.ctl = 14'd0;
      q.push_back(it);
   endtask

   task automatic pc(input logic [3:0] st, input logic [13:0] ctl);
      item_t it;
      it.st = st; it.rdy = 1'b1; it.ck = 1'b1; it.ctl = ctl;
      q.push_back(it);
   endtask

   task automatic drain(input string tag, input logic [5:0] o, input logic [5:0] f);
      item_t it;
      op = o;
      funct = f;
      while (q.size() > 0) begin
         it = q.pop_front();
         @(negedge clk);
         mem_ready = it.rdy;
         #1;
         chk({tag, "_state"}, 32'(state), 32'(it.st));
         if (it.ck) chk({tag, "_ctl"}, 32'(ctl_obs), 32'(it.ctl));
         pcw_n += int'(pc_write);
         irw_n += int'(ir_write);
         rw_n  += int'(reg_write);
      end
   endtask

   task automatic idle(input string tag, input int cnt);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk({tag, "_fetch"}, 32'(state), 0);
      chk({tag, "_retired"}, 32'(instr_retired), 32'(cnt));
   endtask

   initial begin
      #3;
      chk("rst_state", 32'(state), 0);
      chk("rst_retired", 32'(instr_retired), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_strobes", 32'({mem_read, ir_write, pc_write, reg_write}), 0);
      @(negedge clk);
      rst = 1'b1;
      // addi, lw, sw, addu back to back with memory always ready
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      pc(4'd10, cw(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0));
      pc(4'd11, cw(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0));
      drain("addi", 6'h08, 6'h00);
      ps(4'd0, 1'b1); ps(4'd1, 1'b1); ps(4'd2, 1'b1); ps(4'd3, 1'b1);
      pc(4'd4, cw(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0));
      drain("lw", 6'h23, 6'h00);
      ps(4'd0, 1'b1); ps(4'd1, 1'b1); ps(4'd2, 1'b1); ps(4'd5, 1'b1);
      drain("sw", 6'h2B, 6'h00);
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      pc(4'd6, cw(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd2, 1'b0));
      pc(4'd7, cw(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 3'd0, 1'b0));
      drain("addu", 6'h00, 6'h21);
      idle("seq", 4);
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      pc(4'd10, cw(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd3, 1'b1));
      ps(4'd11, 1'b1);
      drain("ori", 6'h0D, 6'h00);
      idle("ori", 5);
      // reset pulse while lw waits in MEM_RD
      ps(4'd0, 1'b1); ps(4'd1, 1'b1); ps(4'd2, 1'b1);
      drain("rst_lw", 6'h23, 6'h00);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("pre_rst_state", 32'(state), 3);
      chk("pre_rst_mem_read", 32'(mem_read), 1);
      #1 rst = 1'b0;
      #1;
      chk("in_rst_state", 32'(state), 0);
      chk("in_rst_retired", 32'(instr_retired), 0);
      chk("in_rst_mem_read", 32'(mem_read), 0);
      chk("in_rst_reg_write", 32'(reg_write), 0);
      mem_ready = 1'b1;
      #1;
      chk("in_rst_fetch_strobes", 32'({pc_write, ir_write, mem_write}), 0);
      #3 rst = 1'b1;
      #1;
      chk("post_rst_state", 32'(state), 0);
      chk("post_rst_fetch", 32'({mem_read, iord, alu_src_a, alu_src_b, alu_op, pc_src}), 32'(13'b1_0_0_01_000_00));
      chk("post_rst_pw_irw", 32'({pc_write, ir_write}), 3);
      chk("post_rst_retired", 32'(instr_retired), 0);
      mem_ready = 1'b0;
      // lw with 3 stalled FETCH cycles and 2 stalled MEM_RD cycles
      pcw_n = 0; irw_n = 0; rw_n = 0;
      ps(4'd0, 1'b0); ps(4'd0, 1'b0); ps(4'd0, 1'b0); ps(4'd0, 1'b1);
      ps(4'd1, 1'b1); ps(4'd2, 1'b1);
      ps(4'd3, 1'b0); ps(4'd3, 1'b0); ps(4'd3, 1'b1);
      ps(4'd4, 1'b1);
      drain("lw_stall", 6'h23, 6'h00);
      chk("lw_stall_pc_write_pulses", 32'(pcw_n), 1);
      chk("lw_stall_ir_write_pulses", 32'(irw_n), 1);
      chk("lw_stall_reg_write_cycles", 32'(rw_n), 1);
      idle("lw_stall", 1);
      zero = 1'b1;
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      pc(4'd8, cw(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 3'd1, 1'b0));
      drain("beq", 6'h04, 6'h00);
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      pc(4'd8, cw(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 3'd1, 1'b0));
      drain("bne", 6'h05, 6'h00);
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      pc(4'd9, cw(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd2, 3'd0, 1'b0));
      drain("jal", 6'h03, 6'h00);
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      pc(4'd12, cw(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0));
      drain("jr", 6'h00, 6'h08);
      idle("ctl_flow", 5);
      @(negedge clk);
      rst = 1'b0;
      #2 rst = 1'b1;
      #1 chk("pulse_retired", 32'(instr_retired), 0);
      // illegal opcode: halting instance freezes, NOP instance retires and refetches
      ps(4'd0, 1'b1); ps(4'd1, 1'b1);
      drain("illegal", 6'h3F, 6'h00);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ready = 1'b1;
         #1;
         chk("halt_state", 32'(state), 13);
         chk("halt_flag", 32'(halted), 1);
         chk("halt_strobes", 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}), 0);
         chk("halt_retired", 32'(instr_retired), 0);
         if (i == 0) begin
            chk("nop_state", 32'(b_state), 0);
            chk("nop_retired", 32'(b_instr_retired), 1);
            chk("nop_halted", 32'(b_halted), 0);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
